// File: rtl/filter_preset_ctrl.sv
// Front-panel preset selector for the biquad coefficient bank.
// Define FILTER_PRESET_AUTO_REPEAT_EN to enable hold-to-repeat stepping.
module filter_preset_ctrl #(
  parameter int NUM_PRESETS = 8,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 25,
  parameter int HOLD_CYC    = 25_000_000,
  parameter int RPT_CYC     = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_tick,
  input  logic             up_level,
  input  logic             dn_tick,
  input  logic             dn_level,
  input  logic             cfg_ready,
  output logic             cfg_valid,
  output logic [IDX_W-1:0] cfg_idx,
  output logic [IDX_W-1:0] target_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PRESETS - 1);

  state_t           state;
  logic             up_rpt;
  logic             dn_rpt;
  logic             up_ev;
  logic             dn_ev;
  logic [IDX_W-1:0] tnext;

`ifdef FILTER_PRESET_AUTO_REPEAT_EN
  logic [1:0] tick;
  logic [1:0] lvl;
  logic [1:0] rpt;

  assign tick   = {dn_tick, up_tick};
  assign lvl    = {dn_level, up_level};
  assign up_rpt = rpt[0];
  assign dn_rpt = rpt[1];

  for (genvar b = 0; b < 2; b++) begin : g_rpt
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             phase;
    logic             hold;
    logic [CNT_W-1:0] thr;

    // Only one button held alone keeps the repeat alive
    assign hold   = lvl[b] && !lvl[1-b];
    assign thr    = phase ? CNT_W'(RPT_CYC - 1) : CNT_W'(HOLD_CYC - 1);
    assign rpt[b] = armed && hold && (cnt == thr);

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt   <= '0;
        armed <= 1'b0;
        phase <= 1'b0;
      end else if (tick[b]) begin
        cnt   <= '0;
        armed <= 1'b1;
        phase <= 1'b0;
      end else if (armed && hold) begin
        if (rpt[b]) begin
          cnt   <= '0;
          phase <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt   <= '0;
        armed <= 1'b0;
        phase <= 1'b0;
      end
    end
  end
`else
  localparam int rpt_cfg_unused = CNT_W + HOLD_CYC + RPT_CYC;
  logic levels_unused;

  assign levels_unused = up_level ^ dn_level;
  assign up_rpt        = 1'b0;
  assign dn_rpt        = 1'b0;
`endif

  assign up_ev = up_tick | up_rpt;
  assign dn_ev = dn_tick | dn_rpt;

  always_comb begin
    tnext = target_idx;
    unique case (1'b1)
      up_ev && !dn_ev:
        tnext = (target_idx == LAST) ? '0 : target_idx + 1'b1;
      dn_ev && !up_ev:
        tnext = (target_idx == '0) ? LAST : target_idx - 1'b1;
      default:
        tnext = target_idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= INIT;
      cfg_valid  <= 1'b0;
      cfg_idx    <= '0;
      target_idx <= '0;
      busy       <= 1'b1;
    end else begin
      target_idx <= tnext;
      unique case (state)
        INIT: begin
          cfg_idx   <= '0;
          cfg_valid <= 1'b1;
          state     <= REQ;
          busy      <= 1'b1;
        end
        IDLE: begin
          if (tnext != cfg_idx) begin
            cfg_idx   <= tnext;
            cfg_valid <= 1'b1;
            state     <= REQ;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          // Pending steps coalesce into one back-to-back load
          if (cfg_valid && cfg_ready) begin
            if (tnext != cfg_idx) begin
              cfg_idx <= tnext;
            end else begin
              cfg_valid <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          cfg_valid <= 1'b0;
          state     <= INIT;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_preset_ctrl.sv
// Directed bench for filter_preset_ctrl with a cycle model.
// Build with FILTER_PRESET_AUTO_REPEAT_EN to cover the repeat section.
module tb_filter_preset_ctrl;

  localparam int N    = 8;
  localparam int W    = 3;
  localparam int HOLD = 10;
  localparam int RPT  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         up_tick = 1'b0;
  logic         up_level = 1'b0;
  logic         dn_tick = 1'b0;
  logic         dn_level = 1'b0;
  logic         cfg_ready = 1'b1;
  logic         cfg_valid;
  logic [W-1:0] cfg_idx;
  logic [W-1:0] target_idx;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;

  filter_preset_ctrl #(
    .NUM_PRESETS(N),
    .IDX_W(W),
    .CNT_W(25),
    .HOLD_CYC(HOLD),
    .RPT_CYC(RPT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up_tick(up_tick),
    .up_level(up_level),
    .dn_tick(dn_tick),
    .dn_level(dn_level),
    .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid),
    .cfg_idx(cfg_idx),
    .target_idx(target_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 = power-up load pending, 1 = idle, 2 = load offered
  int m_phase = 0;
  int m_target = 0;
  int m_idx = 0;
  int m_valid = 0;
  int m_busy = 1;
  int m_up_held = -1;
  int m_dn_held = -1;
  bit started = 1'b0;

  function automatic bit rpt_due(input int held, input bit mine, input bit other);
`ifdef FILTER_PRESET_AUTO_REPEAT_EN
    if (held < HOLD || !mine || other) return 1'b0;
    return ((held - HOLD) % RPT) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int held_next(input int held, input bit tk, input bit mine, input bit other);
    if (tk) return 1;
    if (held >= 0 && mine && !other) return held + 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit up_ev;
    bit dn_ev;
    int tn;
    started = 1'b1;
    if (!reset) begin
      m_phase = 0; m_target = 0; m_idx = 0;
      m_valid = 0; m_busy = 1;
      m_up_held = -1; m_dn_held = -1;
    end else begin
      up_ev = up_tick | rpt_due(m_up_held, up_level, dn_level);
      dn_ev = dn_tick | rpt_due(m_dn_held, dn_level, up_level);
      tn = m_target;
      if (up_ev && !dn_ev) tn = (tn + 1) % N;
      if (dn_ev && !up_ev) tn = (tn + N - 1) % N;
      if (m_phase == 0) begin
        m_idx = 0; m_valid = 1; m_phase = 2;
      end else if (m_phase == 1) begin
        if (tn != m_idx) begin
          m_idx = tn; m_valid = 1; m_phase = 2;
        end
      end else if (cfg_ready) begin
        if (tn != m_idx) m_idx = tn;
        else begin
          m_valid = 0; m_phase = 1;
        end
      end
      m_busy = (m_phase != 1);
      m_target = tn;
      m_up_held = held_next(m_up_held, up_tick, up_level, dn_level);
      m_dn_held = held_next(m_dn_held, dn_tick, dn_level, up_level);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", int'(cfg_valid), m_valid);
      chk("model_idx", int'(cfg_idx), m_idx);
      chk("model_target", int'(target_idx), m_target);
      chk("model_busy", int'(busy), m_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit u, input bit d);
    up_tick = u;
    dn_tick = d;
    step();
    up_tick = 1'b0;
    dn_tick = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_valid", int'(cfg_valid), 0);
    chk("rst_idx", int'(cfg_idx), 0);
    chk("rst_target", int'(target_idx), 0);

    reset = 1'b1;
    chk("init_busy", int'(busy), 1);
    chk("init_valid", int'(cfg_valid), 0);
    step();
    chk("boot_valid", int'(cfg_valid), 1);
    chk("boot_idx", int'(cfg_idx), 0);
    step();
    chk("boot_done_valid", int'(cfg_valid), 0);
    chk("boot_done_busy", int'(busy), 0);

    up_tick = 1'b1;
    step();
    up_tick = 1'b0;
    chk("up_valid", int'(cfg_valid), 1);
    chk("up_idx", int'(cfg_idx), 1);
    chk("up_target", int'(target_idx), 1);
    step();
    chk("up_drop", int'(cfg_valid), 0);

    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("at7_target", int'(target_idx), 7);
    up_tick = 1'b1;
    step();
    up_tick = 1'b0;
    chk("wrap_up_idx", int'(cfg_idx), 0);
    step();
    dn_tick = 1'b1;
    step();
    dn_tick = 1'b0;
    chk("wrap_dn_idx", int'(cfg_idx), 7);
    step();

    repeat (4) pulse(1'b1, 1'b0);
    chk("at3_target", int'(target_idx), 3);
    up_tick = 1'b1;
    dn_tick = 1'b1;
    step();
    up_tick = 1'b0;
    dn_tick = 1'b0;
    chk("both_valid", int'(cfg_valid), 0);
    chk("both_target", int'(target_idx), 3);

    pulse(1'b0, 1'b1);
    cfg_ready = 1'b0;
    repeat (3) pulse(1'b1, 1'b0);
    chk("coal_valid", int'(cfg_valid), 1);
    chk("coal_idx", int'(cfg_idx), 3);
    chk("coal_target", int'(target_idx), 5);
    cfg_ready = 1'b1;
    step();
    chk("b2b_valid", int'(cfg_valid), 1);
    chk("b2b_idx", int'(cfg_idx), 5);
    step();
    chk("b2b_drop", int'(cfg_valid), 0);

    cfg_ready = 1'b0;
    pulse(1'b0, 1'b1);
    chk("mid_valid", int'(cfg_valid), 1);
    chk("mid_idx", int'(cfg_idx), 4);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", int'(cfg_valid), 0);
    chk("mid_rst_idx", int'(cfg_idx), 0);
    chk("mid_rst_target", int'(target_idx), 0);
    reset = 1'b1;
    cfg_ready = 1'b1;
    step();
    chk("reboot_valid", int'(cfg_valid), 1);
    chk("reboot_idx", int'(cfg_idx), 0);
    step();

    cfg_ready = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("net0_idx", int'(cfg_idx), 1);
    cfg_ready = 1'b1;
    step();
    chk("net0_drop", int'(cfg_valid), 0);
    chk("net0_target", int'(target_idx), 1);
    step();
    chk("net0_quiet", int'(cfg_valid), 0);

`ifdef FILTER_PRESET_AUTO_REPEAT_EN
    pulse(1'b0, 1'b1);
    chk("rpt_start", int'(target_idx), 0);
    up_tick = 1'b1;
    up_level = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      up_tick = 1'b0;
      if (k == 10) chk("rpt_before_hold", int'(target_idx), 1);
      if (k == 11) chk("rpt_first", int'(target_idx), 2);
      if (k == 15) chk("rpt_second", int'(target_idx), 3);
    end
    up_level = 1'b0;
    chk("rpt_final", int'(target_idx), 4);
    repeat (3) step();
    chk("rpt_release", int'(target_idx), 4);

    up_tick = 1'b1;
    up_level = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      up_tick = 1'b0;
      if (k == 5) dn_level = 1'b1;
    end
    up_level = 1'b0;
    dn_level = 1'b0;
    step();
    chk("rpt_both_stop", int'(target_idx), 5);
    repeat (3) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
